rtp_packet_framer: RTL and testbench

//  Downstream of the SDI packetizer. Buffers its 32-bit payload words (no backpressure) in a FIFO and

---
 rtl/rtp_packet_framer_if.sv | 24 ++
 rtl/rtp_packet_framer.sv | 205 ++++++++++++++++++++
 tb/tb_rtp_packet_framer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtp_packet_framer_if.sv
// Stream bundle for the RTP framer: payload words in from the SDI packetizer,
// framed packet words out to the UDP/IP encapsulation stage.
interface rtp_packet_framer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        ts_tick;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        overflow;

  modport master (
    input  in_data, in_valid, in_last, ts_tick, out_ready,
    output out_data, out_valid, out_sop, out_eop, overflow
  );

  modport slave (
    output in_data, in_valid, in_last, ts_tick, out_ready,
    input  out_data, out_valid, out_sop, out_eop, overflow
  );
endinterface

// File: rtl/rtp_packet_framer.sv
// Buffers payload words and emits RTP packets (3 header words + 1..PAYLOAD_WORDS
// payload words); a packet closes early with M=1 on the last word of a video frame.
module rtp_packet_framer #(
  parameter int unsigned PAYLOAD_WORDS = 8,
  parameter int unsigned FIFO_DEPTH    = 32,
  parameter int unsigned LAST_DEPTH    = 4,
  parameter logic [6:0]  PT            = 7'd96,
  parameter logic [31:0] SSRC          = 32'h5354_3131
) (
  input logic                  clk,
  input logic                  rst_n,
  rtp_packet_framer_if.master  pkt_if
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(LAST_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PW_L    = (AW+1)'(PAYLOAD_WORDS);
  localparam logic [LW:0] LQ_L    = (LW+1)'(LAST_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_PAY
  } state_t;

  logic [31:0]   mem_q    [FIFO_DEPTH];
  logic [AW-1:0] lq_mem_q [LAST_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [LW:0]   lq_wr_q, lq_rd_q;
  logic [31:0]   ts_cnt_q;
  logic          overflow_q;

  state_t        state_q;
  logic [31:0]   out_data_q;
  logic          out_valid_q, out_sop_q, out_eop_q;
  logic [15:0]   seq_q;
  logic          frame_start_q;
  logic [31:0]   pkt_ts_q;
  logic          pkt_m_q;
  logic [AW:0]   len_q, cnt_q;

  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic [LW:0]   lq_count;
  logic          lq_full, lq_empty;
  logic          wr_en, drop;
  logic [AW-1:0] wr_idx, rd_idx, lq_head;
  logic [AW-1:0] dist_mod;
  logic [AW:0]   dist_d;
  logic          eof_fits, start_d, start_m_d;
  logic [AW:0]   start_len_d;
  logic          hs;
  logic [31:0]   head_word;

  always_comb begin
    fifo_count = wr_ptr_q - rd_ptr_q;
    fifo_full  = (fifo_count == DEPTH_L);
    lq_count   = lq_wr_q - lq_rd_q;
    lq_full    = (lq_count == LQ_L);
    lq_empty   = (lq_count == '0);
    wr_idx     = wr_ptr_q[AW-1:0];
    rd_idx     = rd_ptr_q[AW-1:0];
    lq_head    = lq_mem_q[lq_rd_q[LW-1:0]];
    head_word  = mem_q[rd_idx];
    wr_en      = pkt_if.in_valid && !fifo_full && (!pkt_if.in_last || !lq_full);
    drop       = pkt_if.in_valid && !wr_en;
    hs         = out_valid_q && pkt_if.out_ready;
  end

  // A frame end sitting in the last FIFO slot wraps dist to 0; it means a full FIFO.
  always_comb begin
    dist_mod    = lq_head - rd_idx + 1'b1;
    dist_d      = (dist_mod == '0) ? DEPTH_L : {1'b0, dist_mod};
    eof_fits    = !lq_empty && (dist_d <= PW_L);
    start_m_d   = eof_fits;
    start_d     = eof_fits || (fifo_count >= PW_L);
    start_len_d = eof_fits ? dist_d : PW_L;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= pkt_if.in_data;
      if (pkt_if.in_last) begin
        lq_mem_q[lq_wr_q[LW-1:0]] <= wr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      lq_wr_q    <= '0;
      ts_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pkt_if.ts_tick) begin
        ts_cnt_q <= ts_cnt_q + 1'b1;
      end
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pkt_if.in_last) begin
          lq_wr_q <= lq_wr_q + 1'b1;
        end
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Payload words are popped into the output register as the previous word hands off,
  // so the last-queue entry is retired on the eop handshake of an M=1 packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      rd_ptr_q      <= '0;
      lq_rd_q       <= '0;
      seq_q         <= '0;
      frame_start_q <= 1'b1;
      pkt_ts_q      <= '0;
      pkt_m_q       <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q     <= ST_HDR0;
            out_valid_q <= 1'b1;
            out_sop_q   <= 1'b1;
            out_eop_q   <= 1'b0;
            out_data_q  <= {2'b10, 1'b0, 1'b0, 4'b0000, start_m_d, PT, seq_q};
            pkt_m_q     <= start_m_d;
            len_q       <= start_len_d;
            if (frame_start_q) begin
              pkt_ts_q <= ts_cnt_q;
            end
          end
        end
        ST_HDR0: begin
          if (hs) begin
            state_q    <= ST_HDR1;
            out_sop_q  <= 1'b0;
            out_data_q <= pkt_ts_q;
          end
        end
        ST_HDR1: begin
          if (hs) begin
            state_q    <= ST_HDR2;
            out_data_q <= SSRC;
          end
        end
        ST_HDR2: begin
          if (hs) begin
            state_q    <= ST_PAY;
            out_data_q <= head_word;
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            cnt_q      <= (AW+1)'(1);
            out_eop_q  <= (len_q == (AW+1)'(1));
          end
        end
        ST_PAY: begin
          if (hs) begin
            if (out_eop_q) begin
              state_q       <= ST_IDLE;
              out_valid_q   <= 1'b0;
              out_eop_q     <= 1'b0;
              out_data_q    <= '0;
              seq_q         <= seq_q + 1'b1;
              frame_start_q <= pkt_m_q;
              if (pkt_m_q) begin
                lq_rd_q <= lq_rd_q + 1'b1;
              end
            end else begin
              out_data_q <= head_word;
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              cnt_q      <= cnt_q + 1'b1;
              out_eop_q  <= ((cnt_q + 1'b1) == len_q);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_sop_q   <= 1'b0;
          out_eop_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_if.out_data  = out_data_q;
  assign pkt_if.out_valid = out_valid_q;
  assign pkt_if.out_sop   = out_sop_q;
  assign pkt_if.out_eop   = out_eop_q;
  assign pkt_if.overflow  = overflow_q;

endmodule

// File: tb/tb_rtp_packet_framer.sv
// Directed bench for rtp_packet_framer: collects handshaken output beats and
// compares whole packets against hand-computed header/payload values.
module tb_rtp_packet_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtp_packet_framer_if bus();

  rtp_packet_framer #(
    .PAYLOAD_WORDS(8),
    .FIFO_DEPTH   (32),
    .LAST_DEPTH   (4),
    .PT           (7'd96),
    .SSRC         (32'h5354_3131)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pkt_if(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    int          cyc;
  } beat_t;

  beat_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q.push_back('{d: bus.out_data, sop: bus.out_sop, eop: bus.out_eop, cyc: cyc});
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic tick = 1'b0);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.ts_tick  = tick;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.ts_tick  = 1'b0;
  endtask

  task automatic tick();
    bus.ts_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.ts_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input string tag);
    for (int i = 0; i < 400 && q.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_val({tag, "_beats"}, 32'(q.size()), 32'(n));
  endtask

  task automatic check_pkt(input int base, input string tag, input logic [31:0] hdr0,
                           input logic [31:0] ts, input int len, input logic [31:0] w0);
    int sops = 0;
    int eops = 0;
    if (q.size() < base + 3 + len) begin
      check_val({tag, "_avail"}, 32'(q.size()), 32'(base + 3 + len));
      return;
    end
    check_val({tag, "_hdr0"}, q[base].d, hdr0);
    check_val({tag, "_hdr1"}, q[base+1].d, ts);
    check_val({tag, "_hdr2"}, q[base+2].d, 32'h5354_3131);
    for (int i = 0; i < len; i++) begin
      check_val($sformatf("%s_pay%0d", tag, i), q[base+3+i].d, w0 + 32'(i));
    end
    for (int i = 0; i < 3 + len; i++) begin
      sops += int'(q[base+i].sop);
      eops += int'(q[base+i].eop);
    end
    check_val({tag, "_sop_first"}, 32'(q[base].sop), 32'd1);
    check_val({tag, "_eop_last"}, 32'(q[base+2+len].eop), 32'd1);
    check_val({tag, "_sop_cnt"}, 32'(sops), 32'd1);
    check_val({tag, "_eop_cnt"}, 32'(eops), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_d;
    logic        held_e;
    int          stall_bad;
    int          qs_before;

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.ts_tick   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sop", 32'(bus.out_sop), 32'd0);
    check_val("rst_eop", 32'(bus.out_eop), 32'd0);
    check_val("rst_ovf", 32'(bus.overflow), 32'd0);
    check_val("rst_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: full 8-word packet, no bubbles
    q.delete();
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
    wait_beats(11, "t1");
    check_pkt(0, "t1", 32'h8060_0000, 32'd0, 8, 32'h1);
    if (q.size() >= 11) check_val("t1_contig", 32'(q[10].cyc - q[0].cyc), 32'd10);

    // 2: short frame-end packet with M=1, then seq advances
    do_reset();
    send(32'h11, 1'b0);
    send(32'h12, 1'b0);
    send(32'h13, 1'b1);
    wait_beats(6, "t2");
    check_pkt(0, "t2", 32'h80E0_0000, 32'd0, 3, 32'h11);
    send(32'h14, 1'b1);
    wait_beats(10, "t2b");
    check_pkt(6, "t2b", 32'h80E0_0001, 32'd0, 1, 32'h14);

    // 3: frame split 8/8/4, timestamp latched once per frame
    q.delete();
    repeat (5) tick();
    for (int i = 0; i < 20; i++) send(32'h100 + 32'(i), (i == 19), (i == 14));
    wait_beats(29, "t3");
    check_pkt(0,  "t3a", 32'h8060_0002, 32'd5, 8, 32'h100);
    check_pkt(11, "t3b", 32'h8060_0003, 32'd5, 8, 32'h108);
    check_pkt(22, "t3c", 32'h80E0_0004, 32'd5, 4, 32'h110);

    // 4: backpressure mid-payload
    q.delete();
    for (int i = 0; i < 8; i++) send(32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 200 && q.size() < 5; i++) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    qs_before = q.size();
    @(negedge clk);
    held_d = bus.out_data;
    held_e = bus.out_eop;
    check_val("t4_stall_valid", 32'(bus.out_valid), 32'd1);
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_data !== held_d || bus.out_eop !== held_e || bus.out_valid !== 1'b1) stall_bad++;
    end
    check_val("t4_stall_stable", 32'(stall_bad), 32'd0);
    check_val("t4_stall_nobeat", 32'(q.size()), 32'(qs_before));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_beats(11, "t4");
    check_pkt(0, "t4", 32'h8060_0005, 32'd6, 8, 32'h200);

    // 5: overflow on the 33rd word while output is stalled
    q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(32'h300 + 32'(i), 1'b0);
    check_val("t5_ovf_before", 32'(bus.overflow), 32'd0);
    send(32'h320, 1'b0);
    check_val("t5_ovf_set", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    wait_beats(44, "t5");
    for (int k = 0; k < 4; k++) begin
      check_pkt(11 * k, $sformatf("t5p%0d", k), 32'h8060_0006 + 32'(k), 32'd6, 8,
                32'h300 + 32'(8 * k));
    end
    check_val("t5_ovf_sticky", 32'(bus.overflow), 32'd1);

    // 6: sequence wrap, then reset mid-payload
    q.delete();
    force dut.seq_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.seq_q;
    send(32'h400, 1'b1);
    wait_beats(4, "t6a");
    check_pkt(0, "t6a", 32'h80E0_FFFF, 32'd6, 1, 32'h400);
    send(32'h401, 1'b1);
    wait_beats(8, "t6b");
    check_pkt(4, "t6b", 32'h80E0_0000, 32'd6, 1, 32'h401);

    q.delete();
    for (int i = 0; i < 4; i++) send(32'h500 + 32'(i), (i == 3));
    for (int i = 0; i < 200 && q.size() < 4; i++) @(posedge clk);
    #1;
    check_val("t6_pay_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check_val("t6_async_ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    send(32'h600, 1'b1);
    wait_beats(4, "t6c");
    check_pkt(0, "t6c", 32'h80E0_0000, 32'd0, 1, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
